// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 VGA timing from a 100 MHz clock (25 MHz pixel enable, h/v counters, sync pulses)
//   clk      : 100 MHz system clock
//   reset    : asynchronous active-high reset
//   hsync    : horizontal sync, active-low, registered
//   vsync    : vertical sync, active-low, registered
//   video_on : high while x/y lie inside the visible area
//   p_tick   : one-clk pixel enable, every 4th clk
//   x, y     : current pixel column and line
module vga_sync_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y
);
    localparam logic [9:0] H_VIS = 10'(H_DISPLAY);
    localparam logic [9:0] H_SS  = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] H_SE  = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] H_MAX = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_VIS = 10'(V_DISPLAY);
    localparam logic [9:0] V_SS  = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] V_SE  = 10'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic [9:0] V_MAX = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);

    logic [1:0] r_div;
    logic [9:0] r_h, r_v;
    logic       r_hs, r_vs;
    logic       w_tick, w_h_end, w_v_end;
    logic [9:0] w_h_next, w_v_next;

    always_comb begin
        w_tick   = r_div == 2'd3;
        w_h_end  = r_h == H_MAX;
        w_v_end  = r_v == V_MAX;
        w_h_next = w_tick ? (w_h_end ? 10'd0 : r_h + 10'd1) : r_h;
        w_v_next = (w_tick && w_h_end) ? (w_v_end ? 10'd0 : r_v + 10'd1) : r_v;
    end

    // Syncs are decoded from the next-state counts so they switch on the same edge as x/y.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div <= 2'd0;
            r_h   <= 10'd0;
            r_v   <= 10'd0;
            r_hs  <= 1'b1;
            r_vs  <= 1'b1;
        end else begin
            r_div <= r_div + 2'd1;
            r_h   <= w_h_next;
            r_v   <= w_v_next;
            r_hs  <= !(w_h_next >= H_SS && w_h_next < H_SE);
            r_vs  <= !(w_v_next >= V_SS && w_v_next < V_SE);
        end
    end

    assign p_tick   = w_tick;
    assign x        = r_h;
    assign y        = r_v;
    assign hsync    = r_hs;
    assign vsync    = r_vs;
    assign video_on = (r_h < H_VIS) && (r_v < V_VIS);
endmodule
